// File: rtl/ttl_mux_demux_latch.sv
// Receive side of a 74157-style time-multiplexed bus: gathers one phase per strobe
// and presents the whole word on A_2D, packed the same way as the mux's A_2D input.
module ttl_mux_demux_latch #(
  parameter int BLOCKS       = 4,
  parameter int WIDTH_IN     = 2,
  parameter int WIDTH_SELECT = (WIDTH_IN > 1) ? $clog2(WIDTH_IN) : 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Enable_bar,
  input  logic                       Strobe,
  input  logic [WIDTH_SELECT-1:0]    Select,
  input  logic [BLOCKS-1:0]          Y_in,
  output logic [BLOCKS*WIDTH_IN-1:0] A_2D,
  output logic                       Valid,
  output logic                       Seq_err,
  output logic                       Busy
);

  localparam int NBITS = BLOCKS * WIDTH_IN;
  localparam logic [WIDTH_SELECT-1:0] LAST  = WIDTH_SELECT'(WIDTH_IN - 1);
  // A resynchronising beat on phase 0 leaves phase 1 expected, unless a word is one phase.
  localparam logic [WIDTH_SELECT-1:0] START = (WIDTH_IN > 1) ? WIDTH_SELECT'(1) : '0;

  logic [WIDTH_SELECT-1:0] exp_q;
  logic [WIDTH_SELECT-1:0] exp_d;
  logic [NBITS-1:0]        shadow_q;
  logic [NBITS-1:0]        merged;
  logic                    accept;
  logic                    in_order;
  logic                    capture;
  logic                    complete;

  always_comb begin
    accept   = Strobe && !Enable_bar;
    in_order = (Select == exp_q);

    // Selects outside 0..WIDTH_IN-1 match no slot and leave the shadow untouched.
    merged = shadow_q;
    for (int i = 0; i < BLOCKS; i++) begin
      for (int s = 0; s < WIDTH_IN; s++) begin
        if (WIDTH_SELECT'(s) == Select) merged[i*WIDTH_IN+s] = Y_in[i];
      end
    end

    capture  = accept && (in_order || (Select == '0));
    complete = capture && (in_order ? (exp_q == LAST) : (WIDTH_IN == 1));

    exp_d = exp_q;
    if (accept) begin
      if (in_order)           exp_d = (exp_q == LAST) ? '0 : exp_q + WIDTH_SELECT'(1);
      else if (Select == '0)  exp_d = START;
      else                    exp_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      exp_q    <= '0;
      shadow_q <= '0;
      A_2D     <= '0;
      Valid    <= 1'b0;
      Seq_err  <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      exp_q   <= exp_d;
      Valid   <= complete;
      Seq_err <= accept && !in_order;
      Busy    <= (exp_d != '0);
      if (capture)  shadow_q <= merged;
      if (complete) A_2D     <= merged;
    end
  end

endmodule

// File: tb/tb_ttl_mux_demux_latch.sv
// Directed bench for ttl_mux_demux_latch at BLOCKS=4, WIDTH_IN=2.
module tb_ttl_mux_demux_latch;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Enable_bar;
  logic       Strobe;
  logic [0:0] Select;
  logic [3:0] Y_in;
  logic [7:0] A_2D;
  logic       Valid;
  logic       Seq_err;
  logic       Busy;

  int tests  = 0;
  int failed = 0;

  ttl_mux_demux_latch #(.BLOCKS(4), .WIDTH_IN(2)) dut (
    .Clk(Clk), .Reset(Reset), .Enable_bar(Enable_bar), .Strobe(Strobe),
    .Select(Select), .Y_in(Y_in), .A_2D(A_2D), .Valid(Valid),
    .Seq_err(Seq_err), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Expected word from the two phase values: bit i*2+s = phase s, block i.
  function automatic logic [7:0] pack(input logic [3:0] y0, input logic [3:0] y1);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*2]   = y0[i];
      r[i*2+1] = y1[i];
    end
    return r;
  endfunction

  // Behaviour of a 74157 bank fed with a packed word.
  function automatic logic [3:0] mux157(input logic [7:0] a, input logic sel);
    logic [3:0] y;
    for (int i = 0; i < 4; i++) y[i] = a[i*2 + int'(sel)];
    return y;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic st, input logic sel, input logic [3:0] y,
                      input logic en_b, input logic rst);
    Strobe     = st;
    Select     = sel;
    Y_in       = y;
    Enable_bar = en_b;
    Reset      = rst;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] a, input logic v,
                         input logic e, input logic b);
    chk({tag, ".a2d"},  32'(A_2D),    32'(a));
    chk({tag, ".valid"}, 32'(Valid),  32'(v));
    chk({tag, ".err"},  32'(Seq_err), 32'(e));
    chk({tag, ".busy"}, 32'(Busy),    32'(b));
  endtask

  initial begin
    logic [3:0] y0, y1;
    int valids;

    // Reset overrides a strobe on phase 0.
    step(1'b1, 1'b0, 4'hF, 1'b0, 1'b1);
    chk_out("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk_out("rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // Basic word.
    step(1'b1, 1'b0, 4'b1010, 1'b0, 1'b0);
    chk_out("basic_b0", 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    chk_out("basic_b1", 8'h6C, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk_out("basic_hold", 8'h6C, 1'b0, 1'b0, 1'b0);

    // Round trip through a 74157.
    chk("rt_sel0", 32'(mux157(A_2D, 1'b0)), 32'(4'b1010));
    chk("rt_sel1", 32'(mux157(A_2D, 1'b1)), 32'(4'b0110));

    // Phase 1 with nothing pending.
    step(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
    chk_out("err1", 8'h6C, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk_out("err1_after", 8'h6C, 1'b0, 1'b0, 1'b0);

    // Repeated phase 0 restarts the word on the second beat.
    step(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
    chk_out("err2_b0", 8'h6C, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'b0011, 1'b0, 1'b0);
    chk_out("err2_b0again", 8'h6C, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 4'b0101, 1'b0, 1'b0);
    chk_out("err2_b1", 8'h27, 1'b1, 1'b0, 1'b0);

    // Enable_bar freezes a partial word.
    step(1'b1, 1'b0, 4'b1100, 1'b0, 1'b0);
    chk_out("en_b0", 8'h27, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
    chk_out("en_hold1", 8'h27, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
    chk_out("en_hold2", 8'h27, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
    chk_out("en_hold3", 8'h27, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 4'b1001, 1'b0, 1'b0);
    chk_out("en_b1", 8'hD2, 1'b1, 1'b0, 1'b0);

    // Reset mid-word drops the partial word and clears A_2D.
    step(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
    chk_out("rmid_b0", 8'hD2, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk_out("rmid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    chk_out("rmid_b1", 8'h00, 1'b0, 1'b1, 1'b0);

    // Streaming: eight words back to back.
    valids = 0;
    for (int w = 0; w < 8; w++) begin
      y0 = 4'(w * 5 + 3);
      y1 = 4'(~(w * 3));
      step(1'b1, 1'b0, y0, 1'b0, 1'b0);
      chk($sformatf("stream%0d_b0_valid", w), 32'(Valid), 32'(0));
      step(1'b1, 1'b1, y1, 1'b0, 1'b0);
      if (Valid === 1'b1) valids++;
      chk($sformatf("stream%0d_valid", w), 32'(Valid), 32'(1));
      chk($sformatf("stream%0d_a2d", w), 32'(A_2D), 32'(pack(y0, y1)));
    end
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    chk("stream_end_valid", 32'(Valid), 32'(0));
    chk("stream_count", 32'(valids), 32'(8));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
